// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per stage, valid/ready on both ends.
// Optional subtract support is enabled by defining PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] load;

`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    // A stage may load when it, or any stage downstream of it, has a free slot
    // this cycle (load[k] = !v[k] || load[k+1], with out_ready closing the chain).
    always_comb begin
        logic        free;
        int unsigned idx;
        load = '0;
        free = out_ready;
        for (int unsigned j = 0; j < STAGES; j++) begin
            idx       = STAGES - 1 - j;
            free      = free | ~v[idx];
            load[idx] = free;
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vr;
        logic [WIDTH-1:0] ar;
        logic [WIDTH-1:0] br;
        logic [WIDTH-1:0] sr;
        logic             cr;

        logic             src_v;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] nxt_s;

        if (k == 0) begin : g_src_in
            assign src_v = in_valid;
            assign src_a = a;
            assign src_b = b_eff;
            assign src_s = '0;
            assign src_c = cin_eff;
        end else begin : g_src_prev
            assign src_v = g_stage[k-1].vr;
            assign src_a = g_stage[k-1].ar;
            assign src_b = g_stage[k-1].br;
            assign src_s = g_stage[k-1].sr;
            assign src_c = g_stage[k-1].cr;
        end

        assign part = {1'b0, src_a[k*CHUNK +: CHUNK]}
                    + {1'b0, src_b[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_c};

        always_comb begin
            nxt_s                    = src_s;
            nxt_s[k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vr <= 1'b0;
                ar <= '0;
                br <= '0;
                sr <= '0;
                cr <= 1'b0;
            end else if (load[k]) begin
                vr <= src_v;
                ar <= src_a;
                br <= src_b;
                sr <= nxt_s;
                cr <= part[CHUNK];
            end
        end

        assign v[k] = vr;
    end

    assign out_valid = v[STAGES-1];
    assign sum       = out_valid ? g_stage[STAGES-1].sr : '0;
    assign cout      = out_valid & g_stage[STAGES-1].cr;
    assign ovf       = out_valid
                     & (g_stage[STAGES-1].ar[WIDTH-1] == g_stage[STAGES-1].br[WIDTH-1])
                     & (g_stage[STAGES-1].sr[WIDTH-1] != g_stage[STAGES-1].ar[WIDTH-1]);

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder for the MIPS datapath; the next generation of the single-bit full-adder cell.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, so the clock period is bounded by a WIDTH/STAGES ripple rather than a full WIDTH ripple.
- Valid/ready handshake on input and output; sustains one operation per cycle with back-pressure.
- Intended for multi-cycle ALU paths such as address generation and the EX-stage adder when timing is tight.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. WIDTH % STAGES must equal 0; CHUNK = WIDTH/STAGES; a violation is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract request (effective only with the optional feature)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of bit WIDTH-1
- ovf  out  1  signed (two's-complement) overflow

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits cleared.
  - Outputs forced to out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 once reset deasserts.
  - Reset mid-operation discards every in-flight operation; nothing is emitted after release until new operands are accepted.
- Transfers:
  - Input accepted on a clk edge with in_valid && in_ready.
  - Output consumed on a clk edge with out_valid && out_ready.
- Pipeline: stage registers S0..S(STAGES-1), each holding a valid bit, the partial sum of low bits, the carry, and the untouched high operand bits.
  - Stage k computes bits [k*CHUNK +: CHUNK] from the carry out of stage k-1; stage 0 uses cin, or cin XOR sub with the feature enabled.
- Advance rule: stage k loads from stage k-1 (or from the inputs for k=0) when stage k is empty, or when stage k's contents move on in the same cycle.
  - The last stage moves on when out_valid && out_ready.
  - in_ready = !S0.valid || S0 moves on this cycle. Combinational back-pressure through the chain is allowed.
- Latency: out_valid rises exactly STAGES cycles after the accepting edge when out_ready is held high.
- Throughput: one result per cycle with in_valid=1 and out_ready=1 continuously.
- Stall: with out_ready=0, the last stage holds; upstream stages fill. After STAGES accepts with no output consumed, in_ready=0.
  - sum, cout and ovf stay stable while out_valid && !out_ready.
- Simultaneous accept and consume in a full pipe: both occur, and occupancy is unchanged.
- Arithmetic:
  - {cout, sum} = a + b' + cin', where b' = b and cin' = cin without the feature.
  - ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]).
  - Wrap-around is modulo 2^WIDTH, with the carry reported on cout.
- Ordering: results emerge strictly in acceptance order; no bubbles are inserted when downstream is ready.
- No X propagation: payload registers of an invalid stage are don't-care internally, but outputs are zero while out_valid=0.

Optional Feature:
- Macro PIPELINED_ADDER_SUB_EN.
- Defined: sub is sampled with the operands and pipelined with them.
  - When sub=1, b' = ~b and cin' = cin XOR 1, so sub=1, cin=0 gives a - b.
  - cout is then the not-borrow, and ovf uses b' (signed subtract overflow).
- Undefined: sub is ignored (treated as 0), and no extra pipeline state is added.

Test Plan:
- Reset sanity: rst_n=0 for 3 cycles, then release → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Basic add and latency: a=0x0000FFFF, b=0x00000001, cin=0, out_ready=1 → after 4 cycles sum=0x00010000, cout=0, ovf=0.
- Full carry ripple across every stage boundary: a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=1 → sum=0x80000000, ovf=1, cout=0.
  - With PIPELINED_ADDER_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-pressure: stream 6 operand pairs (i, i+1) with out_ready=0.
  - Required: in_ready falls after the 4th accept, and results stay stable.
  - Then raise out_ready → sums 1,3,5,7,9,11 emitted in order, one per cycle.
- Reset mid-stream: stream 3 ops, assert rst_n=0 for 1 cycle → out_valid stays 0, and no stale result appears after release.
